sar_avg_filter: RTL and testbench
=================================

// Module: sar_avg_filter
// PURPOSE
//  Downstream consumer of the successive-approximation ADC FSM.
//  - Detects each completed conversion from the FSM's done / digitized_successive outputs.
//  - Accumulates a block of 2**LOG2_SAMPLES codes and emits their truncated mean as a
//    one-cycle-valid result for the display/scaling path.
//  - Removes conversion-to-conversion LSB jitter before BCD/voltage scaling.
// PARAMETERS
//  WIDTH        8  bit width of ADC code in and averaged code out
//  LOG2_SAMPLES 4  log2 of block length (4 -> 16 samples); legal range 0..8
// PORTS
//  clk          in   1            system clock; single clock domain
//  reset        in   1            synchronous, active-high reset
//  enable       in   1            1 = accumulate; 0 = flush and idle
//  conv_done    in   1            FSM done level; high for the whole READY dwell (many cycles)
//  conv_data    in   WIDTH        FSM digitized_successive; updates on the edge done falls
//  avg_data     out  WIDTH        latest block mean; held between results
//  avg_valid    out  1            1-cycle pulse when avg_data updates
//  sample_cnt   out  LOG2_SAMPLES+1  samples accumulated in current block, 0..2**LOG2_SAMPLES-1
//  busy         out  1            1 while in ACCUM with sample_cnt != 0
// BEHAVIOUR
//  Reset: state=IDLE, acc=0, sample_cnt=0, avg_data=0, avg_valid=0, busy=0, done_q=0.
//  Sample strobe:
//   - done_q <= conv_done every cycle.
//   - strobe = done_q & ~conv_done (falling edge).
//   - conv_data is sampled in the strobe cycle, never while conv_done is high; that value
//     is the freshly completed code.
//   - A rising edge or a long-high done never produces a strobe.
//  Accumulator: ACC_W = WIDTH+LOG2_SAMPLES bits, unsigned; it cannot overflow.
//  FSM states:
//   IDLE:
//    - acc=0, sample_cnt=0.
//    - enable=1 -> ACCUM next cycle.
//    - A strobe in the same cycle as enable rising is ignored.
//   ACCUM, on strobe:
//    - If sample_cnt < N-1: acc += conv_data; sample_cnt++.
//    - If sample_cnt == N-1: sum = acc + conv_data; avg_data <= sum >> LOG2_SAMPLES
//      (truncate, no rounding); acc <= 0; sample_cnt <= 0; state -> EMIT.
//   EMIT:
//    - avg_valid=1 for exactly this one cycle; -> ACCUM next cycle.
//    - A strobe landing in EMIT is accumulated as sample 0 of the next block; no loss.
//  Latency: avg_valid asserts 1 cycle after the strobe of the Nth sample.
//  Disable:
//   - enable=0 in any state -> IDLE next cycle; acc and sample_cnt cleared.
//   - The partial block is discarded; avg_data is held; no avg_valid.
//   - If enable falls in EMIT, the avg_valid pulse of that cycle still occurs.
//  Reset mid-block: same as disable, and avg_data also returns to 0.
//  LOG2_SAMPLES=0: every strobe -> EMIT; avg_data = conv_data (pass-through, 1-cycle pulse).
//  Simultaneous reset and strobe: reset wins. Simultaneous disable and strobe: strobe dropped.
//  Outputs avg_data, avg_valid and busy are registered (no combinational path from inputs).
// STRUCTURE
//  Package sar_pkg:
//   - typedef enum logic [1:0] {IDLE, ACCUM, EMIT} avg_state_t;
//   - ADC_WIDTH = 8 constant, shared with the SAR FSM instantiation.
//  Sub-module edge_detect_fall:
//   - Registered falling-edge detector: clk, reset, level in, 1-cycle pulse out.
//   - Reusable for other done/level inputs.
//  Top: edge_detect_fall + one always_ff for FSM/acc/outputs + always_comb next-state.
// TESTING
//  1. Reset, enable=1, 16 strobes of conv_data=8'h80 -> one avg_valid pulse, avg_data=8'h80,
//     sample_cnt back to 0.
//  2. 16 strobes alternating 8'h7F/8'h80 -> avg_data=8'h7F (sum 0x7F8 >>4, truncation);
//     16 strobes of 8'hFF -> avg_data=8'hFF, no overflow.
//  3. conv_done held high 5000 cycles then low, conv_data changing while high
//     -> exactly 1 sample; value = code present when done fell.
//  4. 10 strobes of 8'h40, enable=0 for 1 cycle, re-enable, 16 strobes of 8'h10
//     -> avg_data=8'h10, no pulse at the disable; avg_data held across it.
//  5. Strobe in the EMIT cycle -> sample_cnt=1 after EMIT; next result counts it;
//     reset asserted mid-block -> all outputs 0 next cycle.
//  6. LOG2_SAMPLES=0 build: strobe 8'h5A -> avg_valid pulse 1 cycle later, avg_data=8'h5A.

Source files
------------

// File: rtl/sar_pkg.sv
// rtl/sar_pkg.sv - shared types and constants for the SAR ADC averaging path
//
// Purpose: FSM state encoding for sar_avg_filter and the ADC code width shared
// with the SAR conversion FSM instantiation.
package sar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } avg_state_t;

    localparam int ADC_WIDTH = 8;

endpackage

// File: rtl/edge_detect_fall.sv
// rtl/edge_detect_fall.sv - registered falling-edge detector for level inputs
//
// Purpose: produce a one-cycle pulse in the first cycle a level input is seen low
// after having been high. A level held high for any length gives exactly one pulse,
// and a rising edge gives none.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous, active-high reset (clears the delayed level)
//   level  in   level to watch
//   pulse  out  high for the single cycle where level_q=1 and level=0
module edge_detect_fall (
    input  logic clk,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic level_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level_q & ~level;

endmodule

// File: rtl/sar_avg_filter.sv
// rtl/sar_avg_filter.sv - block averager for completed SAR ADC conversions
//
// Purpose: detect each finished conversion (falling edge of conv_done), sum a block
// of 2**LOG2_SAMPLES codes and emit the truncated mean with a one-cycle valid pulse.
// Ports:
//   clk         in   system clock, single domain
//   reset       in   synchronous, active-high reset
//   enable      in   1 = accumulate, 0 = flush partial block and idle
//   conv_done   in   conversion-complete level from the SAR FSM
//   conv_data   in   conversion code, valid in the cycle conv_done is first seen low
//   avg_data    out  latest block mean, held between results
//   avg_valid   out  one-cycle pulse when avg_data updates
//   sample_cnt  out  samples accumulated in the current block
//   busy        out  high while accumulating a non-empty block
module sar_avg_filter
    import sar_pkg::*;
#(
    parameter int WIDTH        = ADC_WIDTH,
    parameter int LOG2_SAMPLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    conv_done,
    input  logic [WIDTH-1:0]        conv_data,
    output logic [WIDTH-1:0]        avg_data,
    output logic                    avg_valid,
    output logic [LOG2_SAMPLES:0]   sample_cnt,
    output logic                    busy
);

    localparam int ACC_W = WIDTH + LOG2_SAMPLES;
    localparam int CNT_W = LOG2_SAMPLES + 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'((1 << LOG2_SAMPLES) - 1);

    avg_state_t         state;
    avg_state_t         state_n;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_n;
    logic [ACC_W-1:0]   sum;
    logic [CNT_W-1:0]   cnt_n;
    logic [WIDTH-1:0]   avg_n;
    logic               emit_n;
    logic               strobe;

    edge_detect_fall u_done_edge (
        .clk   (clk),
        .reset (reset),
        .level (conv_done),
        .pulse (strobe)
    );

    always_comb begin
        state_n = state;
        acc_n   = acc;
        cnt_n   = sample_cnt;
        avg_n   = avg_data;
        emit_n  = 1'b0;
        sum     = acc + ACC_W'(conv_data);

        case (state)
            IDLE: begin
                // A strobe coinciding with enable rising is deliberately ignored.
                acc_n = '0;
                cnt_n = '0;
                if (enable) begin
                    state_n = ACCUM;
                end
            end
            ACCUM, EMIT: begin
                // EMIT behaves like ACCUM with an empty block, so a strobe there
                // becomes sample 0 of the next block.
                state_n = ACCUM;
                if (strobe) begin
                    if (sample_cnt == LAST_CNT) begin
                        avg_n   = sum[ACC_W-1:LOG2_SAMPLES];
                        acc_n   = '0;
                        cnt_n   = '0;
                        state_n = EMIT;
                        emit_n  = 1'b1;
                    end else begin
                        acc_n = sum;
                        cnt_n = sample_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_n = IDLE;
                acc_n   = '0;
                cnt_n   = '0;
            end
        endcase

        // Disable overrides everything: partial block dropped, mean held.
        if (!enable) begin
            state_n = IDLE;
            acc_n   = '0;
            cnt_n   = '0;
            avg_n   = avg_data;
            emit_n  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            acc        <= '0;
            sample_cnt <= '0;
            avg_data   <= '0;
            avg_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            acc        <= acc_n;
            sample_cnt <= cnt_n;
            avg_data   <= avg_n;
            avg_valid  <= emit_n;
            busy       <= (state_n == ACCUM) && (cnt_n != '0);
        end
    end

endmodule

// File: tb/tb_sar_avg_filter.sv
// tb/tb_sar_avg_filter.sv - self-checking bench for sar_avg_filter
module tb_sar_avg_filter;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       conv_done;
    logic [7:0] conv_data;

    logic [7:0] avg_data;
    logic       avg_valid;
    logic [4:0] sample_cnt;
    logic       busy;

    logic [7:0] avg_data0;
    logic       avg_valid0;
    logic [0:0] sample_cnt0;
    logic       busy0;

    always #5 clk = ~clk;

    sar_avg_filter #(.WIDTH(8), .LOG2_SAMPLES(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .conv_done  (conv_done),
        .conv_data  (conv_data),
        .avg_data   (avg_data),
        .avg_valid  (avg_valid),
        .sample_cnt (sample_cnt),
        .busy       (busy)
    );

    sar_avg_filter #(.WIDTH(8), .LOG2_SAMPLES(0)) dut0 (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .conv_done  (conv_done),
        .conv_data  (conv_data),
        .avg_data   (avg_data0),
        .avg_valid  (avg_valid0),
        .sample_cnt (sample_cnt0),
        .busy       (busy0)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: which samples the filter is collecting and the last means.
    bit         accepting;
    int         q[$];
    logic [7:0] m_avg;
    logic [7:0] m_avg0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] want;
    } vec_t;

    vec_t tbl[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total_cnt++;
        if (got === want) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // One conversion: done high for dwell cycles, then falls with code v.
    task automatic strobe(input logic [7:0] v, input int dwell, input bit wiggle, input bit settle);
        int sum;
        bit ev;
        conv_done = 1'b1;
        for (int i = 0; i < dwell; i++) begin
            if (wiggle) conv_data = 8'($urandom);
            tick();
        end
        if (dwell > 100) begin
            check("dwell_cnt", 32'(sample_cnt), 32'(q.size()));
            check("dwell_valid", 32'(avg_valid), 32'd0);
        end
        conv_done = 1'b0;
        conv_data = v;
        tick();
        ev = 1'b0;
        if (accepting) begin
            q.push_back(int'(v));
            m_avg0 = v;
            if (q.size() == 16) begin
                sum = 0;
                foreach (q[k]) sum += q[k];
                m_avg = 8'(sum / 16);
                q.delete();
                ev = 1'b1;
            end
        end
        check("valid", 32'(avg_valid), 32'(ev));
        check("avg", 32'(avg_data), 32'(m_avg));
        check("cnt", 32'(sample_cnt), 32'(q.size()));
        check("busy", 32'(busy), 32'(accepting && q.size() != 0));
        check("l0_valid", 32'(avg_valid0), 32'(accepting));
        check("l0_avg", 32'(avg_data0), 32'(m_avg0));
        if (settle) begin
            tick();
            check("pulse_end", 32'(avg_valid), 32'd0);
            check("held", 32'(avg_data), 32'(m_avg));
            check("l0_pulse_end", 32'(avg_valid0), 32'd0);
        end
    endtask

    task automatic set_enable(input bit b);
        enable = b;
        tick();
        accepting = b;
        if (!b) begin
            q.delete();
            check("dis_valid", 32'(avg_valid), 32'd0);
            check("dis_avg", 32'(avg_data), 32'(m_avg));
            check("dis_cnt", 32'(sample_cnt), 32'd0);
            check("dis_busy", 32'(busy), 32'd0);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        m_avg  = 8'h00;
        m_avg0 = 8'h00;
        q.delete();
        check("rst_avg", 32'(avg_data), 32'd0);
        check("rst_valid", 32'(avg_valid), 32'd0);
        check("rst_cnt", 32'(sample_cnt), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_l0_avg", 32'(avg_data0), 32'd0);
        reset = 1'b0;
        tick();
        accepting = enable;
    endtask

    initial begin
        tbl[0] = '{8'h80, 8'h80, 8'h80};
        tbl[1] = '{8'h7F, 8'h80, 8'h7F};
        tbl[2] = '{8'hFF, 8'hFF, 8'hFF};
        tbl[3] = '{8'h00, 8'h01, 8'h00};
        tbl[4] = '{8'h10, 8'h30, 8'h20};
        tbl[5] = '{8'h00, 8'hFF, 8'h7F};

        reset     = 1'b1;
        enable    = 1'b0;
        conv_done = 1'b0;
        conv_data = 8'h00;
        accepting = 1'b0;
        m_avg     = 8'h00;
        m_avg0    = 8'h00;
        tick();
        tick();
        check("init_avg", 32'(avg_data), 32'd0);
        check("init_valid", 32'(avg_valid), 32'd0);
        check("init_cnt", 32'(sample_cnt), 32'd0);
        check("init_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick();
        set_enable(1'b1);

        // Table-driven blocks of alternating codes.
        foreach (tbl[t]) begin
            for (int i = 0; i < 16; i++) begin
                strobe((i % 2) ? tbl[t].b : tbl[t].a, $urandom_range(1, 3), 1'b0, 1'b1);
            end
            check("tbl_avg", 32'(avg_data), 32'(tbl[t].want));
        end

        // Long done dwell with a changing bus: exactly one sample, value at the fall.
        strobe(8'h21, 5000, 1'b1, 1'b1);
        check("dwell_one", 32'(sample_cnt), 32'd1);
        for (int i = 0; i < 15; i++) strobe(8'($urandom), $urandom_range(1, 4), 1'b1, 1'b1);

        // Partial block discarded by a one-cycle disable.
        for (int i = 0; i < 10; i++) strobe(8'h40, 2, 1'b0, 1'b1);
        set_enable(1'b0);
        set_enable(1'b1);
        for (int i = 0; i < 16; i++) strobe(8'h10, 2, 1'b0, 1'b1);
        check("reenable_avg", 32'(avg_data), 32'h10);

        // Disable landing in the EMIT cycle: pulse already seen, then idle.
        for (int i = 0; i < 15; i++) strobe(8'h30, 2, 1'b0, 1'b1);
        strobe(8'h30, 2, 1'b0, 1'b0);
        set_enable(1'b0);
        set_enable(1'b1);

        // Back-to-back conversions straight after a result: nothing lost.
        for (int i = 0; i < 15; i++) strobe(8'h20, 2, 1'b0, 1'b1);
        strobe(8'h60, 2, 1'b0, 1'b0);
        check("gap_avg", 32'(avg_data), 32'h24);
        strobe(8'h08, 1, 1'b0, 1'b1);
        check("post_emit_cnt", 32'(sample_cnt), 32'd1);
        for (int i = 0; i < 15; i++) strobe(8'h08, 2, 1'b0, 1'b1);
        check("post_emit_avg", 32'(avg_data), 32'h08);

        // Reset mid-block.
        for (int i = 0; i < 5; i++) strobe(8'h77, 2, 1'b0, 1'b1);
        do_reset();

        // Random blocks with occasional flushes.
        for (int blk = 0; blk < 6; blk++) begin
            for (int s = 0; s < 16; s++) begin
                strobe(8'($urandom), $urandom_range(1, 4), 1'($urandom_range(0, 1)), 1'b1);
                if ($urandom_range(0, 19) == 0) begin
                    set_enable(1'b0);
                    set_enable(1'b1);
                end
            end
        end

        // Single-sample build passes the code straight through.
        strobe(8'h5A, 2, 1'b0, 1'b0);
        check("l0_passthru", 32'(avg_data0), 32'h5A);
        check("l0_pulse", 32'(avg_valid0), 32'd1);
        tick();
        check("l0_pulse_one", 32'(avg_valid0), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
